// File: rtl/sseg_sweep_animator.sv
// sseg_sweep_animator: moves a single lit digit across an N-digit active-low
// 7-segment display, each lit digit showing the hex glyph of its own position.
module sseg_sweep_animator #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 1388889,
    parameter int CNT_W      = 21,
    parameter int POS_W      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [3:0]            rate,
    output logic [NUM_DIGITS-1:0] an,
    output logic [7:0]            sseg,
    output logic [POS_W-1:0]      pos,
    output logic                  step
);
    typedef enum logic {UP, DOWN} dir_t;
    localparam logic [POS_W-1:0] LAST    = POS_W'(NUM_DIGITS - 1);
    localparam logic [POS_W-1:0] ONE     = POS_W'(1);
    localparam logic [CNT_W-1:0] PRE_MAX = CNT_W'(TICK_DIV - 1);
    logic [CNT_W-1:0] pres;
    logic [3:0]       tick_cnt;
    logic             tick, advance, turn;
    dir_t             dir, dir_nxt;
    logic [POS_W-1:0] pos_nxt;

    function automatic logic [7:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 8'hC0;
            4'h1: glyph = 8'hF9;
            4'h2: glyph = 8'hA4;
            4'h3: glyph = 8'hB0;
            4'h4: glyph = 8'h99;
            4'h5: glyph = 8'h92;
            4'h6: glyph = 8'h82;
            4'h7: glyph = 8'hF8;
            4'h8: glyph = 8'h80;
            4'h9: glyph = 8'h90;
            4'hA: glyph = 8'h88;
            4'hB: glyph = 8'h83;
            4'hC: glyph = 8'hC6;
            4'hD: glyph = 8'hA1;
            4'hE: glyph = 8'h86;
            default: glyph = 8'h8E;
        endcase
    endfunction

    assign tick    = en && pres == PRE_MAX;
    assign advance = tick && tick_cnt >= rate;

    // Bounce reflects at the ends without repeating the endpoint
    always_comb begin
        dir_nxt = dir;
        pos_nxt = pos;
        turn    = dir == DOWN ? pos == '0 : pos == LAST;
        if (NUM_DIGITS > 1) begin
            case (mode)
                2'b00: pos_nxt = pos == LAST ? '0 : pos + ONE;
                2'b01: pos_nxt = pos == '0 ? LAST : pos - ONE;
                2'b10: begin
                    dir_nxt = turn ? (dir == UP ? DOWN : UP) : dir;
                    pos_nxt = dir_nxt == DOWN ? pos - ONE : pos + ONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pres     <= '0;
            tick_cnt <= '0;
            pos      <= '0;
            dir      <= UP;
            an       <= ~NUM_DIGITS'(1);
            sseg     <= 8'hC0;
            step     <= 1'b0;
        end else begin
            step <= advance;
            if (en)
                pres <= pres == PRE_MAX ? '0 : pres + CNT_W'(1);
            if (tick)
                tick_cnt <= advance ? '0 : tick_cnt + 4'd1;
            if (advance) begin
                pos  <= pos_nxt;
                dir  <= dir_nxt;
                an   <= ~(NUM_DIGITS'(1) << pos_nxt);
                sseg <= glyph(4'(pos_nxt));
            end
        end
    end
endmodule

// File: doc/sseg_sweep_animator.md
Name: sseg_sweep_animator

Overview:
Parametrised successor to the fixed 4-digit heartbeat sweep. It drives an N-digit multiplexed 7-segment display with a single lit digit that moves across the display. Each lit digit shows the hex glyph of its own position. The block adds a runtime-selectable direction/bounce/hold mode, a runtime step-rate divider and an enable. It sits directly at the board anode/segment pins, or behind a higher-level display mux.

Parameters:
NUM_DIGITS, 4, number of digits/anodes; legal range 1..16
TICK_DIV, 1388889, clk cycles per base tick (100 MHz / 1388889 ≈ 72 Hz); must be ≥2
CNT_W, 21, prescaler width; must satisfy 2^CNT_W ≥ TICK_DIV
POS_W, 4, position register width; must satisfy 2^POS_W ≥ NUM_DIGITS

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
en  in  1  1 = animation runs; 0 = prescaler, rate counter and position frozen
mode  in  2  00 rotate-up, 01 rotate-down, 10 bounce, 11 hold
rate  in  4  animation advances once every rate+1 base ticks
an  out  NUM_DIGITS  active-low anode select, exactly one bit low
sseg  out  8  active-low segments {dp,g,f,e,d,c,b,a}; dp always 1 (off)
pos  out  POS_W  index of the lit digit
step  out  1  one-cycle pulse, high in the cycle after an update to pos/an/sseg

Behaviour:
- Reset (sync, wins over everything): prescaler=0, tick_cnt=0, pos=0, dir=up, an=~1 (bit0 low), sseg=8'hC0, step=0.
- Prescaler: when en=1, counts 0..TICK_DIV-1 and wraps to 0. tick=1 for the single cycle with prescaler==TICK_DIV-1 && en. When en=0, the value holds.
- Rate counter: on tick, if tick_cnt ≥ rate, then advance=1 and tick_cnt←0; otherwise tick_cnt←tick_cnt+1. rate is sampled live; lowering rate below tick_cnt forces a step on the next tick.
- On the advance edge, pos/an/sseg are updated together (all registered), and step←1 for exactly that following cycle. Otherwise step←0.
- Latency: with en held high from reset release, the first update happens after exactly TICK_DIV*(rate+1) clk edges. Updates then repeat at that period.
- Next pos, by mode:
  - 00: pos+1; NUM_DIGITS-1 wraps to 0.
  - 01: pos-1; 0 wraps to NUM_DIGITS-1.
  - 10 (bounce): move in dir. At pos==NUM_DIGITS-1 with dir=up, flip dir and go to NUM_DIGITS-2. At pos==0 with dir=down, flip dir and go to 1. Endpoints are never repeated: for N=4 the sequence is 0,1,2,3,2,1,0,1…
  - 11: pos unchanged, an/sseg unchanged, step still pulses.
- dir changes only in mode 10; it persists across mode changes.
- Mode change takes effect at the next advance; no partial updates.
- NUM_DIGITS=1: pos stays 0 in all modes; step still pulses.
- an = ~(1<<pos). sseg = active-low hex glyph of pos:
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8
  - 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E
- en=0 mid-count: state freezes with no drift. Resuming continues from the held prescaler value.
- reset mid-operation: all state and outputs return to reset values on the next edge; an in-flight step is discarded.

Test Plan:
- TICK_DIV=4, N=4, rate=0, mode=00, en=1 after reset → first update at edge 4 (an=1101, sseg=F9, pos=1, step high 1 cycle). Then an=1011/A4, 0111/B0, 1110/C0 at edges 8/12/16 (wrap).
- Same setup, mode=01 → pos sequence 3,2,1,0,3 with an=0111 first, sseg=B0.
- mode=10, N=4 → pos 1,2,3,2,1,0,1 over 7 updates. With N=16, the sweep reaches pos=F, sseg=8E, an[15]=0, then turns to E.
- rate=2, TICK_DIV=4 → updates every 12 cycles. Change rate 3→0 when tick_cnt=2 → step on the very next tick.
- Drop en for 10 cycles mid-count → update delayed by exactly 10 cycles. mode=11 → step pulses while an/sseg stay constant.
- Assert reset for 1 cycle between ticks at pos=2 → next edge gives an=1110, sseg=C0, pos=0, step=0, and the next update arrives a full 4 cycles later.
